// File: rtl/tomasulo_pkg.sv
// Shared types and constants for the reservation-station dispatch/scheduler slice.
// Imported by the interface, the per-unit slot FSM and the rs_dispatch_sched top.
package tomasulo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } unit_state_e;

    localparam int NUM_RS    = 3;
    localparam int NUM_UNITS = 4;

    localparam int ADD0 = 0;
    localparam int ADD1 = 1;
    localparam int MUL0 = 2;
    localparam int MUL1 = 3;

    localparam int DEF_ADD_LAT = 2;
    localparam int DEF_MUL_LAT = 4;
    localparam int DEF_DIV_LAT = 8;

    localparam int                CNT_W   = 8;
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    // Lowest set bit of an RS ready vector; 0 when the vector is empty.
    function automatic logic [1:0] first_set(input logic [NUM_RS-1:0] v);
        first_set = '0;
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            if (v[i]) first_set = 2'(i);
        end
    endfunction

endpackage

// File: rtl/rs_dispatch_sched_if.sv
// RS-to-scheduler bundle: ready vectors in, dispatch / CDB / clear pulses out.
// Every output is a registered level; a pulse is one cycle long, there is no back-pressure.
interface rs_dispatch_sched_if;
    import tomasulo_pkg::*;

    logic [NUM_RS-1:0]      add_rdy;
    logic [NUM_RS-1:0]      mul_rdy;
    logic [NUM_RS-1:0]      mul_isdiv;
    logic [NUM_UNITS-1:0]   disp_valid;
    logic [2*NUM_UNITS-1:0] disp_idx;
    logic [NUM_UNITS-1:0]   unit_busy;
    logic                   cdb_valid;
    logic [1:0]             cdb_unit;
    logic [1:0]             cdb_idx;
    logic [NUM_RS-1:0]      add_clr;
    logic [NUM_RS-1:0]      mul_clr;
    logic [2*NUM_UNITS-1:0] dbg_state;

    modport slave (
        input  add_rdy, mul_rdy, mul_isdiv,
        output disp_valid, disp_idx, unit_busy, cdb_valid, cdb_unit, cdb_idx,
               add_clr, mul_clr, dbg_state
    );

    modport master (
        output add_rdy, mul_rdy, mul_isdiv,
        input  disp_valid, disp_idx, unit_busy, cdb_valid, cdb_unit, cdb_idx,
               add_clr, mul_clr, dbg_state
    );

endinterface

// File: rtl/rs_dispatch_sched_exec_slot_fsm.sv
// exec_slot_fsm: one functional unit's IDLE -> EXEC -> DONE -> IDLE sequencer and latency counter.
// done is raised on the last EXEC cycle so an uncontended unit is granted without idling in DONE.
module exec_slot_fsm
    import tomasulo_pkg::*;
(
    input  logic             clock1,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] latency,
    input  logic             grant,
    output logic             done,
    output logic             busy,
    output unit_state_e      state
);

    unit_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock1 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = EXEC;
                    cnt_d   = latency - CNT_ONE;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = grant ? IDLE : DONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (grant) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign state = state_q;

endmodule

// File: rtl/rs_dispatch_sched.sv
// rs_dispatch_sched: fixed-priority dispatch of ready RS entries to 2 adders + 2 multipliers,
// round-robin CDB grant of finished units. Define RS_DISPATCH_SCHED_DIV_EN for divide latency.
module rs_dispatch_sched
    import tomasulo_pkg::*;
#(
    parameter int ADD_LAT = DEF_ADD_LAT,
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT
) (
    input  logic               clock1,
    input  logic               reset,
    rs_dispatch_sched_if.slave rs
);

    localparam logic [CNT_W-1:0] ADD_LAT_C = CNT_W'(ADD_LAT);
    localparam logic [CNT_W-1:0] MUL_LAT_C = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_LAT_C = CNT_W'(DIV_LAT);

    logic [NUM_RS-1:0]      add_issued_q, add_issued_d, mul_issued_q, mul_issued_d;
    logic [NUM_RS-1:0]      add_left, mul_left, add_clr_d, mul_clr_d;
    logic [NUM_UNITS-1:0]   unit_load, unit_grant, unit_done, unit_busy;
    logic [1:0]             load_idx   [NUM_UNITS];
    logic [1:0]             held_idx_q [NUM_UNITS];
    logic [CNT_W-1:0]       unit_lat   [NUM_UNITS];
    logic [1:0]             rr_q, gnt_unit, cand;
    logic                   gnt_found;
    logic [NUM_UNITS-1:0]   disp_valid_q;
    logic [2*NUM_UNITS-1:0] disp_idx_q, disp_idx_d;
    logic                   cdb_valid_q;
    logic [1:0]             cdb_unit_q, cdb_idx_q;
    logic [NUM_RS-1:0]      add_clr_q, mul_clr_q;

    // Per class: lowest eligible entry to the lowest idle unit, the next one to the other unit.
    always_comb begin
        add_left   = rs.add_rdy & ~add_issued_q;
        mul_left   = rs.mul_rdy & ~mul_issued_q;
        unit_load  = '0;
        disp_idx_d = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            load_idx[u] = '0;
            unit_lat[u] = ADD_LAT_C;
        end
        for (int u = ADD0; u <= ADD1; u++) begin
            if (!unit_busy[u] && add_left != '0) begin
                unit_load[u] = 1'b1;
                load_idx[u]  = first_set(add_left);
                add_left[load_idx[u]] = 1'b0;
            end
        end
        for (int u = MUL0; u <= MUL1; u++) begin
            if (!unit_busy[u] && mul_left != '0) begin
                unit_load[u] = 1'b1;
                load_idx[u]  = first_set(mul_left);
                mul_left[load_idx[u]] = 1'b0;
            end
`ifdef RS_DISPATCH_SCHED_DIV_EN
            unit_lat[u] = rs.mul_isdiv[load_idx[u]] ? DIV_LAT_C : MUL_LAT_C;
`else
            unit_lat[u] = MUL_LAT_C;
`endif
        end
        for (int u = 0; u < NUM_UNITS; u++) begin
            disp_idx_d[2*u +: 2] = load_idx[u];
        end
    end

    // Round-robin CDB grant starting at rr; the granted entry's issued bit drops with its clr pulse.
    always_comb begin
        gnt_found  = 1'b0;
        gnt_unit   = '0;
        cand       = '0;
        unit_grant = '0;
        add_clr_d  = '0;
        mul_clr_d  = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            cand = rr_q + 2'(k);
            if (!gnt_found && unit_done[cand]) begin
                gnt_found = 1'b1;
                gnt_unit  = cand;
            end
        end
        if (gnt_found) begin
            unit_grant[gnt_unit] = 1'b1;
            if (gnt_unit < 2'(MUL0)) add_clr_d[held_idx_q[gnt_unit]] = 1'b1;
            else                     mul_clr_d[held_idx_q[gnt_unit]] = 1'b1;
        end
        add_issued_d = add_issued_q;
        mul_issued_d = mul_issued_q;
        for (int u = ADD0; u <= ADD1; u++) if (unit_load[u]) add_issued_d[load_idx[u]] = 1'b1;
        for (int u = MUL0; u <= MUL1; u++) if (unit_load[u]) mul_issued_d[load_idx[u]] = 1'b1;
        add_issued_d = add_issued_d & ~add_clr_d;
        mul_issued_d = mul_issued_d & ~mul_clr_d;
    end

    always_ff @(posedge clock1 or posedge reset) begin
        if (reset) begin
            add_issued_q <= '0;
            mul_issued_q <= '0;
            rr_q         <= '0;
            disp_valid_q <= '0;
            disp_idx_q   <= '0;
            cdb_valid_q  <= 1'b0;
            cdb_unit_q   <= '0;
            cdb_idx_q    <= '0;
            add_clr_q    <= '0;
            mul_clr_q    <= '0;
            for (int u = 0; u < NUM_UNITS; u++) held_idx_q[u] <= '0;
        end else begin
            add_issued_q <= add_issued_d;
            mul_issued_q <= mul_issued_d;
            rr_q         <= gnt_found ? gnt_unit + 2'd1 : rr_q;
            disp_valid_q <= unit_load;
            disp_idx_q   <= disp_idx_d;
            cdb_valid_q  <= gnt_found;
            cdb_unit_q   <= gnt_unit;
            cdb_idx_q    <= gnt_found ? held_idx_q[gnt_unit] : 2'd0;
            add_clr_q    <= add_clr_d;
            mul_clr_q    <= mul_clr_d;
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (unit_load[u]) held_idx_q[u] <= load_idx[u];
            end
        end
    end

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_slot
        unit_state_e slot_state;
        exec_slot_fsm u_slot (
            .clock1  (clock1),
            .reset   (reset),
            .load    (unit_load[u]),
            .latency (unit_lat[u]),
            .grant   (unit_grant[u]),
            .done    (unit_done[u]),
            .busy    (unit_busy[u]),
            .state   (slot_state)
        );
        assign rs.dbg_state[2*u +: 2] = slot_state;
    end

`ifndef RS_DISPATCH_SCHED_DIV_EN
    logic unused_div_cfg;
    assign unused_div_cfg = ^{rs.mul_isdiv, DIV_LAT_C};
`endif

    assign rs.disp_valid = disp_valid_q;
    assign rs.disp_idx   = disp_idx_q;
    assign rs.unit_busy  = unit_busy;
    assign rs.cdb_valid  = cdb_valid_q;
    assign rs.cdb_unit   = cdb_unit_q;
    assign rs.cdb_idx    = cdb_idx_q;
    assign rs.add_clr    = add_clr_q;
    assign rs.mul_clr    = mul_clr_q;

endmodule

// File: tb/tb_rs_dispatch_sched.sv
// Directed bench for rs_dispatch_sched (defaults) plus a second instance with ADD_LAT=MUL_LAT=4.
// Honours RS_DISPATCH_SCHED_DIV_EN when choosing the expected divide timing.
module tb_rs_dispatch_sched;

    logic clock1;
    logic reset;
    int   n_vec  = 0;
    int   n_miss = 0;
    logic [3:0] exp_q[$];

    rs_dispatch_sched_if bus ();
    rs_dispatch_sched_if bus2 ();

    rs_dispatch_sched dut (
        .clock1 (clock1),
        .reset  (reset),
        .rs     (bus)
    );

    rs_dispatch_sched #(.ADD_LAT(4), .MUL_LAT(4), .DIV_LAT(8)) dut2 (
        .clock1 (clock1),
        .reset  (reset),
        .rs     (bus2)
    );

    // clock / watchdog
    initial clock1 = 1'b0;
    always #5 clock1 = ~clock1;

    initial begin
        #50000;
        $display("FAIL watchdog: run did not finish, got timeout required finish");
        $fatal(1);
    end

    // checking
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_cdb(input string tag, input logic [10:0] exp);
        check(tag, {bus.cdb_valid, bus.cdb_unit, bus.cdb_idx, bus.add_clr, bus.mul_clr}, exp);
    endtask

    task automatic check_cdb2(input string tag, input logic [10:0] exp);
        check(tag, {bus2.cdb_valid, bus2.cdb_unit, bus2.cdb_idx, bus2.add_clr, bus2.mul_clr}, exp);
    endtask

    task automatic check_disp(input string tag, input logic [11:0] exp);
        check(tag, {bus.disp_valid, bus.disp_idx}, exp);
    endtask

    // scoreboard: every broadcast must match the next expected {unit, idx}
    always @(negedge clock1) begin
        if (!reset && bus.cdb_valid)
            check("cdb_order", {1'b0, bus.cdb_unit, bus.cdb_idx},
                  exp_q.size() != 0 ? {1'b0, exp_q.pop_front()} : 5'h10);
    end

    // drivers
    task automatic drive(input logic [2:0] a, input logic [2:0] m, input logic [2:0] d);
        bus.add_rdy   = a;
        bus.mul_rdy   = m;
        bus.mul_isdiv = d;
    endtask

    task automatic drive2(input logic [2:0] a, input logic [2:0] m);
        bus2.add_rdy   = a;
        bus2.mul_rdy   = m;
        bus2.mul_isdiv = 3'b000;
    endtask

    task automatic tick();
        @(posedge clock1);
        @(negedge clock1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(3'b000, 3'b000, 3'b000);
        drive2(3'b000, 3'b000);
        @(negedge clock1);
        reset = 1'b0;
    endtask

    function automatic logic [10:0] div_exp(input int k);
`ifdef RS_DISPATCH_SCHED_DIV_EN
        if (k == 4) return {1'b1, 2'd3, 2'd1, 3'b000, 3'b010};
        if (k == 8) return {1'b1, 2'd2, 2'd0, 3'b000, 3'b001};
`else
        if (k == 4) return {1'b1, 2'd2, 2'd0, 3'b000, 3'b001};
        if (k == 5) return {1'b1, 2'd3, 2'd1, 3'b000, 3'b010};
`endif
        return '0;
    endfunction

    logic [10:0] all4_exp [5];

    initial begin
        all4_exp = '{{1'b1, 2'd0, 2'd0, 3'b001, 3'b000},
                     {1'b1, 2'd1, 2'd1, 3'b010, 3'b000},
                     {1'b1, 2'd2, 2'd0, 3'b000, 3'b001},
                     {1'b1, 2'd3, 2'd1, 3'b000, 3'b010},
                     11'd0};

        // reset state
        reset = 1'b1;
        drive(3'b000, 3'b000, 3'b000);
        drive2(3'b000, 3'b000);
        repeat (2) @(negedge clock1);
        check("rst_outs", {bus.disp_valid, bus.disp_idx, bus.unit_busy, bus.cdb_valid, bus.cdb_unit,
                           bus.cdb_idx, bus.add_clr, bus.mul_clr}, 32'd0);
        check("rst_state", bus.dbg_state, 32'd0);
        reset = 1'b0;

        // single add, first edge after reset
        drive(3'b001, 3'b000, 3'b000);
        tick();
        check_disp("add1_disp", {4'b0001, 8'h00});
        check("add1_busy", bus.unit_busy, 32'b0001);
        check("add1_state", bus.dbg_state, {24'd0, 8'b0000_0001});
        drive(3'b000, 3'b000, 3'b000);
        exp_q.push_back({2'd0, 2'd0});
        tick();
        check("add1_wait", {bus.cdb_valid, bus.disp_valid}, 32'd0);
        tick();
        check_cdb("add1_cdb", {1'b1, 2'd0, 2'd0, 3'b001, 3'b000});
        tick();
        check_cdb("add1_after", 11'd0);
        check("add1_idle", bus.unit_busy, 32'd0);

        // rdy held: no second dispatch before the clr pulse
        do_reset();
        drive(3'b001, 3'b000, 3'b000);
        tick();
        check_disp("hold_disp", {4'b0001, 8'h00});
        exp_q.push_back({2'd0, 2'd0});
        tick();
        check("hold_e1", bus.disp_valid, 32'd0);
        tick();
        check("hold_e2", {bus.disp_valid, bus.cdb_valid, bus.cdb_unit, bus.cdb_idx, bus.add_clr, bus.mul_clr},
              {4'b0000, 1'b1, 2'd0, 2'd0, 3'b001, 3'b000});
        tick();
        check_disp("hold_redisp", {4'b0001, 8'h00});
        drive(3'b000, 3'b000, 3'b000);
        exp_q.push_back({2'd0, 2'd0});
        tick();
        tick();
        check_cdb("hold_cdb2", {1'b1, 2'd0, 2'd0, 3'b001, 3'b000});
        tick();

        // three ready adds, RS drops each entry on its clr
        do_reset();
        drive(3'b111, 3'b000, 3'b000);
        tick();
        check_disp("add3_disp", {4'b0011, 8'h04});
        exp_q.push_back({2'd0, 2'd0});
        exp_q.push_back({2'd1, 2'd1});
        tick();
        check("add3_nodisp", bus.disp_valid, 32'd0);
        tick();
        check({"add3_cdb0"}, {bus.disp_valid, bus.cdb_valid, bus.cdb_unit, bus.cdb_idx, bus.add_clr, bus.mul_clr},
              {4'b0000, 1'b1, 2'd0, 2'd0, 3'b001, 3'b000});
        drive(3'b110, 3'b000, 3'b000);
        tick();
        check_disp("add3_e2disp", {4'b0001, 8'h02});
        check_cdb("add3_cdb1", {1'b1, 2'd1, 2'd1, 3'b010, 3'b000});
        exp_q.push_back({2'd0, 2'd2});
        drive(3'b100, 3'b000, 3'b000);
        tick();
        check_cdb("add3_gap", 11'd0);
        tick();
        check_cdb("add3_cdb2", {1'b1, 2'd0, 2'd2, 3'b100, 3'b000});
        drive(3'b000, 3'b000, 3'b000);
        tick();

        // rdy withdrawn before dispatch; rdy changes during EXEC ignored
        do_reset();
        drive(3'b111, 3'b000, 3'b000);
        tick();
        check_disp("drop_disp", {4'b0011, 8'h04});
        exp_q.push_back({2'd0, 2'd0});
        exp_q.push_back({2'd1, 2'd1});
        drive(3'b011, 3'b000, 3'b000);
        tick();
        tick();
        check_cdb("drop_cdb0", {1'b1, 2'd0, 2'd0, 3'b001, 3'b000});
        drive(3'b010, 3'b000, 3'b000);
        tick();
        check("drop_e3", {bus.disp_valid, bus.cdb_valid, bus.cdb_unit, bus.cdb_idx, bus.add_clr, bus.mul_clr},
              {4'b0000, 1'b1, 2'd1, 2'd1, 3'b010, 3'b000});
        drive(3'b000, 3'b000, 3'b000);
        tick();
        check("drop_e4", {bus.disp_valid, bus.cdb_valid}, 32'd0);

        // all four units finish on the same edge (second instance)
        do_reset();
        drive2(3'b011, 3'b011);
        tick();
        check("all4_disp", {bus2.disp_valid, bus2.disp_idx}, {4'b1111, 8'h44});
        drive2(3'b000, 3'b000);
        repeat (3) tick();
        check("all4_busy", {bus2.unit_busy, bus2.cdb_valid}, {4'b1111, 1'b0});
        for (int k = 0; k < 5; k++) begin
            tick();
            check_cdb2($sformatf("all4_cdb%0d", k), all4_exp[k]);
        end
        check("all4_idle", bus2.unit_busy, 32'd0);

        // multiplier class index mapping
        do_reset();
        drive(3'b000, 3'b110, 3'b000);
        tick();
        check_disp("mul_disp", {4'b1100, 8'h90});
        drive(3'b000, 3'b000, 3'b000);
        exp_q.push_back({2'd2, 2'd1});
        exp_q.push_back({2'd3, 2'd2});
        repeat (4) tick();
        check_cdb("mul_cdb0", {1'b1, 2'd2, 2'd1, 3'b000, 3'b010});
        tick();
        check_cdb("mul_cdb1", {1'b1, 2'd3, 2'd2, 3'b000, 3'b100});
        tick();

        // divide latency (build-dependent)
        do_reset();
        drive(3'b000, 3'b011, 3'b001);
        tick();
        check_disp("div_disp", {4'b1100, 8'h40});
        drive(3'b000, 3'b000, 3'b000);
`ifdef RS_DISPATCH_SCHED_DIV_EN
        exp_q.push_back({2'd3, 2'd1});
        exp_q.push_back({2'd2, 2'd0});
`else
        exp_q.push_back({2'd2, 2'd0});
        exp_q.push_back({2'd3, 2'd1});
`endif
        for (int k = 1; k <= 9; k++) begin
            tick();
            check_cdb($sformatf("div_k%0d", k), div_exp(k));
        end

        // reset pulse while unit 2 is executing
        do_reset();
        drive(3'b000, 3'b001, 3'b000);
        tick();
        check_disp("rmid_disp", {4'b0100, 8'h00});
        check("rmid_busy", bus.unit_busy, 32'b0100);
        drive(3'b000, 3'b000, 3'b000);
        tick();
        #2 reset = 1'b1;
        #1;
        check("rmid_clear", {bus.unit_busy, bus.disp_valid, bus.cdb_valid, bus.mul_clr, bus.dbg_state}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock1);
            check("rmid_hold", {bus.cdb_valid, bus.unit_busy}, 32'd0);
        end
        reset = 1'b0;
        drive(3'b000, 3'b001, 3'b000);
        tick();
        check_disp("rmid_redisp", {4'b0100, 8'h00});
        drive(3'b000, 3'b000, 3'b000);
        exp_q.push_back({2'd2, 2'd0});
        repeat (3) tick();
        check_cdb("rmid_pre", 11'd0);
        tick();
        check_cdb("rmid_cdb", {1'b1, 2'd2, 2'd0, 3'b000, 3'b001});
        tick();

        check("sb_drain", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/rs_dispatch_sched.md
RS_DISPATCH_SCHED -- requirements
Module: rs_dispatch_sched

Interface
REQ-001 Parameter ADD_LAT, default 2: add/sub execute cycles; SHALL be >=1.
REQ-002 Parameter MUL_LAT, default 4: multiply execute cycles; SHALL be >=1.
REQ-003 Parameter DIV_LAT, default 8: divide execute cycles; SHALL be >=1.
REQ-004 clock1  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 add_rdy  in  3  adder RS entry i has both operands valid and is waiting.
REQ-007 mul_rdy  in  3  multiplier RS entry i has both operands valid and is waiting.
REQ-008 mul_isdiv  in  3  multiplier RS entry i holds a divide.
REQ-009 disp_valid  out  4  one-cycle pulse: unit u (0,1 adders; 2,3 multipliers) accepted an entry.
REQ-010 disp_idx  out  8  2 bits per unit, RS entry index dispatched to unit u.
REQ-011 unit_busy  out  4  unit u not IDLE.
REQ-012 cdb_valid, cdb_unit (2), cdb_idx (2)  out  one-cycle result broadcast: source unit and its RS entry.
REQ-013 add_clr, mul_clr  out  3 each  one-cycle pulse freeing the RS entry, coincident with cdb_valid.

Function
REQ-014 Each unit SHALL be an FSM with states IDLE -> EXEC -> DONE -> IDLE.
REQ-015 Eligible entry: rdy bit set and its internal issued bit clear; issued bits block double dispatch while rdy remains high.
REQ-016 Per edge, per class, the lowest-index eligible entry SHALL go to the lowest-index IDLE unit, then the next eligible entry to the other IDLE unit; up to 4 dispatches per edge.
REQ-017 On dispatch: unit -> EXEC, counter loaded with LAT-1, issued bit set, disp_valid/disp_idx registered high for exactly one cycle.
REQ-018 Latency: adders use ADD_LAT; multipliers use DIV_LAT when mul_isdiv[idx] is sampled high at dispatch, else MUL_LAT.
REQ-019 EXEC: counter decrements each edge; the edge at which the counter is 0 moves the unit to DONE, so EXEC lasts exactly LAT cycles.
REQ-020 Exactly one DONE unit SHALL be granted per edge by round-robin; pointer rr (2 bits) gives priority rr, rr+1, ... mod 4; after a grant, rr = granted+1.
REQ-021 At grant edge: cdb_valid, cdb_unit, cdb_idx and the matching clr bit are registered high for one cycle, the issued bit is cleared, and the unit -> IDLE.
REQ-022 Non-granted DONE units SHALL hold DONE, with no loss and no reordering within a unit.
REQ-023 A unit returning IDLE SHALL be dispatchable at the following edge, never at the grant edge.
REQ-024 An entry whose rdy drops before dispatch is not dispatched; rdy changes during EXEC are ignored.
REQ-025 A rdy entry with no IDLE unit in its class waits without starvation of lower indices being required (fixed priority by design).

Reset
REQ-026 Asserting reset, including mid-EXEC or DONE, SHALL force all units to IDLE, counters to 0, issued bits to 0, rr to 0, and all outputs to 0; in-flight operations are discarded with no broadcast.
REQ-027 First dispatch SHALL be possible at the first edge after reset deasserts.

Configuration
REQ-028 Macro RS_DISPATCH_SCHED_DIV_EN defined: divide latency per REQ-018.
REQ-029 Macro undefined: mul_isdiv is ignored, all multiplier ops use MUL_LAT, and DIV_LAT is unused.

Structure
REQ-030 Package tomasulo_pkg holds:
- unit-state enum (IDLE/EXEC/DONE)
- unit index constants (ADD0=0, ADD1=1, MUL0=2, MUL1=3)
- default latencies
- NUM_RS=3 and NUM_UNITS=4
REQ-031 Sub-module exec_slot_fsm holds one unit's state and counter (load, latency, grant in; done, busy out); it is instantiated 4 times.

Verification
REQ-032 add_rdy=001 for one cycle after reset -> disp_valid=0001 and disp_idx[1:0]=0 next cycle; cdb_valid with cdb_unit=0, cdb_idx=0 and add_clr=001 two cycles after that (ADD_LAT=2).
REQ-033 add_rdy=111 held -> entries 0,1 go to units 0,1 on the same edge; entry 2 dispatches one edge after the first cdb frees a unit.
REQ-034 mul_rdy=011 and add_rdy=011 on the same edge, all units finishing together -> four consecutive cdb cycles in order 0,1,2,3 (rr=0), and none dropped.
REQ-035 With RS_DISPATCH_SCHED_DIV_EN, mul_isdiv=001 and mul_rdy=011 -> entry 1 broadcasts 4 cycles after dispatch and entry 0 after 8; without the macro, both broadcast after 4.
REQ-036 reset pulsed while unit 2 is in EXEC -> unit_busy=0000, no cdb_valid, and a re-presented mul_rdy=001 dispatches cleanly.
REQ-037 rdy held high after dispatch -> no second disp_valid for that entry until after its clr pulse.
